// File: rtl/servo_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM generator.
package servo_pkg;

  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_CNT_W        = 20;
  localparam int DEF_FRAME_CYCLES = 1_000_000;
  localparam int DEF_MIN_PULSE    = 50_000;
  localparam int DEF_MAX_PULSE    = 100_000;
  localparam int DEF_SLEW_STEP    = 1_000;

  // Channel index width; never narrower than one bit, even for a single channel.
  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  // Zero passes through as "channel off"; anything else lands in [min, max].
  function automatic logic [31:0] clamp_width(input logic [31:0] width,
                                               input logic [31:0] min_pulse,
                                               input logic [31:0] max_pulse);
    logic [31:0] res;
    if (width == '0)             res = '0;
    else if (width < min_pulse)  res = min_pulse;
    else if (width > max_pulse)  res = max_pulse;
    else                         res = width;
    return res;
  endfunction

endpackage

// File: rtl/servo_frame_counter.sv
// Free-running frame counter: cnt runs 0..FRAME_CYCLES-1, commit marks the
// last cycle of the frame, frame_tick is a registered pulse following cnt == 0.
module servo_frame_counter
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clr_n,
  output logic [CNT_W-1:0] cnt,
  output logic             commit,
  output logic             frame_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_tick_q, frame_tick_d;

  // Next count with wrap at the frame end, and the start-of-frame marker.
  always_comb begin
    commit       = (cnt_q == LAST);
    cnt_d        = commit ? '0 : cnt_q + CNT_W'(1);
    frame_tick_d = (cnt_q == '0);
  end

  // Counter state; reset holds the count at the start of a frame.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign cnt        = cnt_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator. One shared frame counter feeds NUM_CH
// comparators; widths are written through a valid/ready port, clamped into a
// safe range and only committed to the comparators at the frame boundary.
// Optional slew limiting of the committed width: define SERVO_PWM_SLEW_EN.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter  int NUM_CH       = DEF_NUM_CH,
  parameter  int CNT_W        = DEF_CNT_W,
  parameter  int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter  int MIN_PULSE    = DEF_MIN_PULSE,
  parameter  int MAX_PULSE    = DEF_MAX_PULSE,
  parameter  int SLEW_STEP    = DEF_SLEW_STEP,
  localparam int CH_W         = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_width,
  output logic              wr_err,
  output logic [NUM_CH-1:0] pwm,
  output logic [NUM_CH-1:0] settled,
  output logic              frame_tick
);

  logic [CNT_W-1:0]  cnt;
  logic              commit;

  logic [CNT_W-1:0]  target_q [NUM_CH];
  logic [CNT_W-1:0]  target_d [NUM_CH];
  logic [CNT_W-1:0]  active_q [NUM_CH];
  logic [CNT_W-1:0]  active_d [NUM_CH];
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              wr_err_q, wr_err_d;

  logic              wr_accept;
  logic              ch_in_range;
  logic [CNT_W-1:0]  wr_width_clamped;

  servo_frame_counter #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .CNT_W        (CNT_W)
  ) u_frame_counter (
    .clk        (clk),
    .clr_n      (clr_n),
    .cnt        (cnt),
    .commit     (commit),
    .frame_tick (frame_tick)
  );

  // Move the committed width toward the target by at most SLEW_STEP; switching
  // a channel on or off is never rate-limited.
  function automatic logic [CNT_W-1:0] slew_next(input logic [CNT_W-1:0] act,
                                                 input logic [CNT_W-1:0] tgt);
    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] diff;
    logic [CNT_W-1:0] res;
    step = CNT_W'(SLEW_STEP);
    diff = '0;
    if (tgt == '0 || act == '0) begin
      res = tgt;
    end else if (tgt > act) begin
      diff = tgt - act;
      res  = (diff > step) ? act + step : tgt;
    end else begin
      diff = act - tgt;
      res  = (diff > step) ? act - step : tgt;
    end
    return res;
  endfunction

  // The commit cycle is reserved for loading active from target, so writes
  // stall there and can never race the commit.
  assign wr_ready         = !commit;
  assign wr_accept        = wr_valid && wr_ready;
  assign ch_in_range      = (32'(wr_ch) < 32'(NUM_CH));
  assign wr_width_clamped = CNT_W'(clamp_width(32'(wr_width), 32'(MIN_PULSE), 32'(MAX_PULSE)));

  // Register file update: writes land in target, commit copies into active.
  always_comb begin
    wr_err_d = wr_accept && !ch_in_range;
    for (int i = 0; i < NUM_CH; i++) begin
      target_d[i] = target_q[i];
      active_d[i] = active_q[i];
      if (wr_accept && (32'(wr_ch) == 32'(i))) begin
        target_d[i] = wr_width_clamped;
      end
      if (commit) begin
`ifdef SERVO_PWM_SLEW_EN
        active_d[i] = slew_next(active_q[i], target_q[i]);
`else
        active_d[i] = target_q[i];
`endif
      end
    end
  end

  // Pulse comparators: high while the frame count is below the committed width.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = (cnt < active_q[i]);
    end
  end

  // Width registers, outputs and error flag; reset forces every channel off.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= '0;
        active_q[i] <= '0;
      end
      pwm_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= target_d[i];
        active_q[i] <= active_d[i];
      end
      pwm_q    <= pwm_d;
      wr_err_q <= wr_err_d;
    end
  end

  // A channel is settled once the comparator runs the width last written.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      settled[i] = (active_q[i] == target_q[i]);
    end
  end

  assign pwm    = pwm_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: a monitor measures every pulse frame and checks it
// against a queue of expected per-channel widths pushed by the stimulus.
module tb_servo_pwm_multi;

`ifdef SERVO_PWM_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic        clk;
  logic        clr_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_ch;
  logic [19:0] wr_width;
  logic        wr_err;
  logic [3:0]  pwm;
  logic [3:0]  settled;
  logic        frame_tick;

  // Three-channel instance, so an out-of-range index is expressible on wr_ch.
  logic        e_valid;
  logic        e_ready;
  logic [1:0]  e_ch;
  logic [19:0] e_width;
  logic        e_err;
  logic [2:0]  e_pwm;
  logic [2:0]  e_settled;
  logic        e_tick;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  servo_pwm_multi #(
    .NUM_CH(4), .CNT_W(20), .FRAME_CYCLES(100),
    .MIN_PULSE(5), .MAX_PULSE(20), .SLEW_STEP(3)
  ) dut (
    .clk(clk), .clr_n(clr_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_width(wr_width), .wr_err(wr_err), .pwm(pwm),
    .settled(settled), .frame_tick(frame_tick)
  );

  servo_pwm_multi #(
    .NUM_CH(3), .CNT_W(20), .FRAME_CYCLES(100),
    .MIN_PULSE(5), .MAX_PULSE(20), .SLEW_STEP(3)
  ) dut_err (
    .clk(clk), .clr_n(clr_n), .wr_valid(e_valid), .wr_ready(e_ready),
    .wr_ch(e_ch), .wr_width(e_width), .wr_err(e_err), .pwm(e_pwm),
    .settled(e_settled), .frame_tick(e_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int w0, input int w1, input int w2, input int w3);
    return {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
  endfunction

  // Wait for the next frame start (cnt == 1 cycle) then advance to cnt == v.
  task automatic goto_cnt(input int v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 250) begin
        tests_failed++;
        $display("FAIL goto_cnt: no frame_tick within 250 cycles");
        $fatal(1, "frame_tick timeout");
      end
    end while (!frame_tick);
    repeat (v - 1) @(negedge clk);
  endtask

  task automatic do_write(input logic [1:0] ch, input int w);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_width = 20'(w);
    while (!wr_ready) begin
      @(negedge clk);
      n++;
      if (n > 5) begin
        tests_failed++;
        $display("FAIL do_write: wr_ready stuck low");
        $fatal(1, "write timeout");
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Monitor: one window per frame, from the frame_tick cycle to the next.
  initial begin
    logic [31:0] e;
    int  win_len;
    int  hi_cnt [4];
    int  first_hi [4];
    int  last_hi [4];
    bit  open;
    int  meas;
    open = 1'b0;
    win_len = 0;
    for (int c = 0; c < 4; c++) begin
      hi_cnt[c] = 0; first_hi[c] = 0; last_hi[c] = 0;
    end
    forever begin
      @(negedge clk);
      if (!clr_n) begin
        open = 1'b0;
        continue;
      end
      if (frame_tick) begin
        if (open && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("frame_period", 32'(win_len), 32'd100);
          for (int c = 0; c < 4; c++) begin
            if (hi_cnt[c] == 0) meas = 0;
            else if (first_hi[c] == 0 && last_hi[c] == hi_cnt[c] - 1) meas = hi_cnt[c];
            else meas = 255;
            check($sformatf("pulse_width_ch%0d", c), 32'(meas), 32'(e[8*c +: 8]));
          end
        end
        open = 1'b1;
        win_len = 0;
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
      end
      if (open) begin
        for (int c = 0; c < 4; c++) begin
          if (pwm[c]) begin
            if (hi_cnt[c] == 0) first_hi[c] = win_len;
            last_hi[c] = win_len;
            hi_cnt[c]++;
          end
        end
        win_len++;
      end
    end
  end

  // Stimulus.
  initial begin
    int n;
    clr_n = 1'b0;
    wr_valid = 1'b0; wr_ch = '0; wr_width = '0;
    e_valid = 1'b0; e_ch = '0; e_width = '0;
    #3;
    check("reset_pwm", 32'(pwm), 32'h0);
    check("reset_settled", 32'(settled), 32'hF);
    check("reset_wr_ready", 32'(wr_ready), 32'h1);
    check("reset_frame_tick", 32'(frame_tick), 32'h0);
    check("reset_wr_err", 32'(wr_err), 32'h0);
    check("reset_e_err", 32'(e_err), 32'h0);

    // Frames F1..F8 of the first run.
    exp_q.push_back(pack4(0, 0, 0, 0));
    exp_q.push_back(pack4(0, 0, 0, 0));
    exp_q.push_back(pack4(0, 0, 0, 0));
    exp_q.push_back(pack4(0, 0, 0, 0));
    exp_q.push_back(pack4(0, 0, 10, 0));
    exp_q.push_back(pack4(5, 20, 10, 0));
    exp_q.push_back(pack4(5, 20, 10, 0));
    exp_q.push_back(pack4(5, 20, 10, 7));

    repeat (2) @(negedge clk);
    clr_n = 1'b1;

    goto_cnt(50);                                   // F1
    check("idle_settled", 32'(settled), 32'hF);
    check("idle_pwm", 32'(pwm), 32'h0);

    goto_cnt(50);                                   // F2: out-of-range write
    e_valid = 1'b1; e_ch = 2'd3; e_width = 20'd10;
    @(negedge clk);
    e_valid = 1'b0;
    check("err_pulse", 32'(e_err), 32'h1);
    @(negedge clk);
    check("err_one_cycle", 32'(e_err), 32'h0);
    check("err_no_target_change", 32'(e_settled), 32'h7);

    goto_cnt(50);                                   // F3: in-range write, no error
    e_valid = 1'b1; e_ch = 2'd1; e_width = 20'd10;
    @(negedge clk);
    e_valid = 1'b0;
    check("err_quiet_on_valid_ch", 32'(e_err), 32'h0);
    check("err_dut_settled_ch1", 32'(e_settled), 32'h5);

    goto_cnt(40);                                   // F4: ch2 = 10
    do_write(2'd2, 10);
    check("wr_err_in_range", 32'(wr_err), 32'h0);
    check("settled_after_ch2", 32'(settled), 32'hB);

    goto_cnt(40);                                   // F5: clamping
    check("settled_commit_ch2", 32'(settled), 32'hF);
    do_write(2'd0, 2);
    do_write(2'd1, 500);
    check("settled_after_clamp_wr", 32'(settled), 32'hC);

    goto_cnt(99);                                   // F6 commit cycle
    wr_valid = 1'b1; wr_ch = 2'd3; wr_width = 20'd7;
    check("ready_low_commit", 32'(wr_ready), 32'h0);
    @(negedge clk);
    check("ready_high_cnt0", 32'(wr_ready), 32'h1);
    @(negedge clk);
    wr_valid = 1'b0;
    check("stalled_wr_accepted", 32'(settled), 32'h7);

    goto_cnt(40);                                   // F8: ch0 = 10
    do_write(2'd0, 10);
    check("settled_after_ch0", 32'(settled), 32'hE);

    goto_cnt(3);                                    // F9: reset mid-pulse
    check("pwm_mid_pulse", 32'(pwm), 32'hF);
    clr_n = 1'b0;
    #1;
    check("async_reset_pwm", 32'(pwm), 32'h0);
    check("async_reset_settled", 32'(settled), 32'hF);
    check("async_reset_ready", 32'(wr_ready), 32'h1);
    check("async_reset_tick", 32'(frame_tick), 32'h0);

    // Frames R1..R7 after the second reset.
    exp_q.push_back(pack4(0, 0, 0, 0));
    exp_q.push_back(pack4(0, 0, 0, 0));
    exp_q.push_back(pack4(0, 0, 0, 5));
    exp_q.push_back(pack4(0, 0, 0, SLEW ? 8 : 14));
    exp_q.push_back(pack4(0, 0, 0, SLEW ? 11 : 14));
    exp_q.push_back(pack4(0, 0, 0, 14));
    exp_q.push_back(pack4(0, 0, 0, 0));

    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;

    goto_cnt(50);                                   // R1
    check("post_reset_settled", 32'(settled), 32'hF);
    goto_cnt(40);                                   // R2: ch3 = 5
    do_write(2'd3, 5);
    check("settled_ch3_pending", 32'(settled), 32'h7);
    goto_cnt(40);                                   // R3: ch3 = 14
    check("settled_ch3_5", 32'(settled), 32'hF);
    do_write(2'd3, 14);
    check("settled_ch3_14_pending", 32'(settled), 32'h7);
    goto_cnt(50);                                   // R4
    check("settled_after_commit1", 32'(settled), SLEW ? 32'h7 : 32'hF);
    goto_cnt(50);                                   // R5
    check("settled_after_commit2", 32'(settled), SLEW ? 32'h7 : 32'hF);
    goto_cnt(40);                                   // R6: disable ch3
    check("settled_after_commit3", 32'(settled), 32'hF);
    do_write(2'd3, 0);
    goto_cnt(50);                                   // R7
    check("settled_disabled", 32'(settled), 32'hF);

    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
